// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the HI/LO register pair.
// The result is computed at launch into temp and revealed when the busy window expires.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);
    localparam logic [CntW-1:0] MultCnt = CntW'(MULT_CYCLES);
    localparam logic [CntW-1:0] DivCnt  = CntW'(DIV_CYCLES);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [2:0] {
        OpNone  = 3'd0,
        OpMult  = 3'd1,
        OpMultu = 3'd2,
        OpDiv   = 3'd3,
        OpDivu  = 3'd4,
        OpMthi  = 3'd5,
        OpMtlo  = 3'd6,
        OpRsvd  = 3'd7
    } mdop_e;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StBusy = 1'b1
    } state_e;

    state_e          st_q, st_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [63:0]     temp_q, temp_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;

    // Arithmetic datapath, evaluated on the live operands at the launch edge
    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, b_mag_nz, b_nz;
    logic [31:0] qs_mag, rs_mag, quo_s, rem_s, quo_u, rem_u;
    logic        b_zero;

    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    always_comb begin
        b_zero   = (B == 32'd0);
        a_mag    = A[31] ? (~A + 32'd1) : A;
        b_mag    = B[31] ? (~B + 32'd1) : B;
        // Divisor forced nonzero so the dividers never see 0; that result is discarded
        b_mag_nz = b_zero ? 32'd1 : b_mag;
        b_nz     = b_zero ? 32'd1 : B;
        // Magnitude divide then sign fix: truncates toward zero and handles 0x80000000 / -1
        qs_mag   = a_mag / b_mag_nz;
        rs_mag   = a_mag % b_mag_nz;
        quo_s    = (A[31] ^ B[31]) ? (~qs_mag + 32'd1) : qs_mag;
        rem_s    = A[31] ? (~rs_mag + 32'd1) : rs_mag;
        quo_u    = A / b_nz;
        rem_u    = A % b_nz;
    end

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        temp_d = temp_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        unique case (st_q)
            StIdle: begin
                if (start) begin
                    case (mdop_e'(mdop))
                        OpMult: begin
                            temp_d = prod_s;
                            cnt_d  = MultCnt;
                            st_d   = StBusy;
                        end
                        OpMultu: begin
                            temp_d = prod_u;
                            cnt_d  = MultCnt;
                            st_d   = StBusy;
                        end
                        OpDiv: begin
                            temp_d = b_zero ? {hi_q, lo_q} : {rem_s, quo_s};
                            cnt_d  = DivCnt;
                            st_d   = StBusy;
                        end
                        OpDivu: begin
                            temp_d = b_zero ? {hi_q, lo_q} : {rem_u, quo_u};
                            cnt_d  = DivCnt;
                            st_d   = StBusy;
                        end
                        OpMthi:  hi_d = A;
                        OpMtlo:  lo_d = A;
                        default: ;
                    endcase
                end
            end
            StBusy: begin
                if (cnt_q <= CntOne) begin
                    hi_d  = temp_q[63:32];
                    lo_d  = temp_q[31:0];
                    cnt_d = '0;
                    st_d  = StIdle;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q   <= StIdle;
            cnt_q  <= '0;
            temp_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            temp_q <= temp_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    assign busy = (st_q == StBusy);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: the driver pushes expected completions, a monitor
// pops and compares them whenever busy falls; idle ops are checked against the model.
module tb_md_unit;

    localparam int unsigned MultCycles = 5;
    localparam int unsigned DivCycles  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    md_unit #(
        .MULT_CYCLES(MultCycles),
        .DIV_CYCLES (DivCycles)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .mdop (mdop),
        .A    (A),
        .B    (B),
        .busy (busy),
        .HI   (HI),
        .LO   (LO)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] m_hi  = 32'd0;
    logic [31:0] m_lo  = 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: plain 64-bit arithmetic; returns {HI, LO} after the operation
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] hi,
                                               input logic [31:0] lo);
        int              sa, sb;
        longint          q, r, p;
        longint unsigned ua, ub;
        sa = a;
        sb = b;
        ua = 64'(a);
        ub = 64'(b);
        case (op)
            3'd1: begin
                p = longint'(sa) * longint'(sb);
                return p;
            end
            3'd2: return ua * ub;
            3'd3: begin
                if (b == 32'd0) return {hi, lo};
                q = longint'(sa) / longint'(sb);
                r = longint'(sa) % longint'(sb);
                return {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 32'd0) return {hi, lo};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: return {hi, lo};
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 4 * DivCycles; i++) begin
            if (!busy) break;
            cyc();
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL wait_idle: busy stuck, got 1 expected 0");
        end
    endtask

    // Launch one op; optionally inject ignored mtlo/div requests during the busy window
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit inject);
        logic [63:0] r;
        bit          launch;
        launch = (op >= 3'd1 && op <= 3'd4);
        r = ref_result(op, a, b, m_hi, m_lo);
        start = 1'b1;
        mdop  = op;
        A     = a;
        B     = b;
        cyc();
        start = 1'b0;
        mdop  = 3'($urandom);
        A     = $urandom;
        B     = $urandom;
        if (launch) begin
            exp_q.push_back('{hi: r[63:32], lo: r[31:0],
                              len: (op <= 3'd2) ? int'(MultCycles) : int'(DivCycles)});
            m_hi = r[63:32];
            m_lo = r[31:0];
            check("busy_after_launch", 32'(busy), 32'd1);
            if (inject) begin
                cyc();
                start = 1'b1;
                mdop  = 3'd6;
                A     = 32'h0000DEAD;
                cyc();
                mdop  = 3'd3;
                A     = $urandom;
                B     = $urandom_range(1, 100);
                cyc();
                start = 1'b0;
            end
            wait_idle();
        end else begin
            if (op == 3'd5) m_hi = a;
            if (op == 3'd6) m_lo = a;
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_hi", HI, m_hi);
            check("idle_lo", LO, m_lo);
        end
    endtask

    // Monitor: measures each busy window and scores the result that appears after it
    int          run_len = 0;
    bit          hold_ok = 1'b1;
    logic [31:0] hold_hi, hold_lo;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            run_len = 0;
        end else if (busy) begin
            if (run_len == 0) begin
                hold_hi = HI;
                hold_lo = LO;
                hold_ok = 1'b1;
            end else if (HI !== hold_hi || LO !== hold_lo) begin
                hold_ok = 1'b0;
            end
            run_len++;
        end else if (run_len != 0) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_completion: got busy window %0d expected none", run_len);
            end else begin
                e = exp_q.pop_front();
                check("busy_len", 32'(run_len), 32'(e.len));
                check("result_hi", HI, e.hi);
                check("result_lo", LO, e.lo);
                check("hold_during_busy", 32'(hold_ok), 32'd1);
            end
            run_len = 0;
        end
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        reset = 1'b1;
        start = 1'b0;
        mdop  = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        cyc();
        cyc();
        reset = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);

        do_op(3'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
        check("mult_hi_const", HI, 32'hFFFFFFFF);
        check("mult_lo_const", LO, 32'hFFFFFFFE);
        do_op(3'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
        check("multu_hi_const", HI, 32'h00000001);
        check("multu_lo_const", LO, 32'hFFFFFFFE);
        do_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        check("div_hi_const", HI, 32'hFFFFFFFF);
        check("div_lo_const", LO, 32'hFFFFFFFD);
        do_op(3'd4, 32'd7, 32'd2, 1'b0);
        check("divu_hi_const", HI, 32'd1);
        check("divu_lo_const", LO, 32'd3);
        do_op(3'd5, 32'h00001234, 32'd0, 1'b0);
        do_op(3'd6, 32'h00005678, 32'd0, 1'b0);
        do_op(3'd4, 32'd5, 32'd0, 1'b0);
        check("div0_hi_const", HI, 32'h00001234);
        check("div0_lo_const", LO, 32'h00005678);
        do_op(3'd1, 32'h00012345, 32'hFFFF0003, 1'b1);
        do_op(3'd5, 32'hCAFEBABE, 32'd0, 1'b0);
        check("mthi_hi_const", HI, 32'hCAFEBABE);
        do_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        check("ovf_hi_const", HI, 32'd0);
        check("ovf_lo_const", LO, 32'h80000000);
        do_op(3'd0, 32'h11111111, 32'd0, 1'b0);
        do_op(3'd7, 32'h22222222, 32'd0, 1'b0);

        // Reset lands in the third busy cycle of a div
        start = 1'b1;
        mdop  = 3'd3;
        A     = 32'd1000;
        B     = 32'd7;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        exp_q.delete();
        cyc();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("abort_idle_busy", 32'(busy), 32'd0);
            check("abort_idle_hilo", HI | LO, 32'd0);
        end

        for (int n = 0; n < 60; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1: begin
                    a = 32'h80000000;
                    b = 32'hFFFFFFFF;
                end
                2:       b = $urandom_range(1, 16);
                default: ;
            endcase
            if ($urandom_range(0, 5) == 0) begin
                // start low with a tempting mdop must not touch state
                mdop = 3'd5;
                A    = $urandom;
                cyc();
                check("nostart_hi", HI, m_hi);
                check("nostart_lo", LO, m_lo);
            end
            do_op(op, a, b, 1'($urandom_range(0, 1)));
        end

        cyc();
        cyc();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
